// File: rtl/ultrasonic_scan_scheduler.sv
// rtl/ultrasonic_scan_scheduler.sv - round-robin ultrasonic trigger/echo scheduler
// One timing engine is shared by up to 4 sensors; results are published per sensor slot.
module ultrasonic_scan_scheduler #(
    parameter int NUM_SENSORS     = 2,
    parameter int CLK_PER_US      = 100,
    parameter int TRIG_US         = 10,
    parameter int ECHO_TIMEOUT_US = 30000,
    parameter int GAP_US          = 60000,
    parameter int US_PER_CM       = 58
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_SENSORS-1:0]      echo,
    output logic [NUM_SENSORS-1:0]      trig,
    output logic [NUM_SENSORS*10-1:0]   distance,
    output logic [NUM_SENSORS-1:0]      dist_valid,
    output logic [NUM_SENSORS-1:0]      timeout,
    output logic                        sample_pulse,
    output logic [1:0]                  sample_id,
    output logic                        busy
);

    localparam int MAX_A  = (TRIG_US > ECHO_TIMEOUT_US) ? TRIG_US : ECHO_TIMEOUT_US;
    localparam int MAX_US = (MAX_A > GAP_US) ? MAX_A : GAP_US;
    localparam int US_W   = $clog2(MAX_US + 1);
    localparam int PS_W   = $clog2(CLK_PER_US + 1);
    localparam int SUB_W  = $clog2(US_PER_CM + 1);
    localparam logic [9:0] CM_MAX = 10'd1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    logic [PS_W-1:0]            presc_q, presc_d;
    logic [US_W-1:0]            us_q, us_d;
    logic [SUB_W-1:0]           sub_q, sub_d;
    logic [9:0]                 cm_q, cm_d;
    logic [NUM_SENSORS-1:0]     echo_meta_q, echo_meta_d;
    logic [NUM_SENSORS-1:0]     echo_sync_q, echo_sync_d;
    logic [NUM_SENSORS-1:0]     echo_prev_q, echo_prev_d;
    logic [NUM_SENSORS*10-1:0]  distance_q, distance_d;
    logic [NUM_SENSORS-1:0]     valid_q, valid_d;
    logic [NUM_SENSORS-1:0]     timeout_q, timeout_d;
    logic                       pulse_q, pulse_d;
    logic [1:0]                 sample_id_q, sample_id_d;

    logic [NUM_SENSORS-1:0]     idx_onehot;
    logic                       tick;
    logic                       echo_cur;
    logic                       echo_last;
    logic                       echo_rise;
    logic                       echo_fall;
    logic [SUB_W-1:0]           sub_nxt;
    logic [9:0]                 cm_nxt;
    logic                       finish_ok;
    logic                       finish_to;

    always_comb begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            idx_onehot[i] = (idx_q == 2'(i));
        end
    end

    assign tick      = (presc_q == PS_W'(CLK_PER_US - 1));
    assign echo_cur  = |(echo_sync_q & idx_onehot);
    assign echo_last = |(echo_prev_q & idx_onehot);
    assign echo_rise = echo_cur & ~echo_last;
    assign echo_fall = ~echo_cur & echo_last;

    // Tick-inclusive counts, so an echo falling on a tick cycle still counts that microsecond.
    always_comb begin
        sub_nxt = sub_q;
        cm_nxt  = cm_q;
        if (tick) begin
            if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                sub_nxt = '0;
                if (cm_q != CM_MAX) begin
                    cm_nxt = cm_q + 10'd1;
                end
            end else begin
                sub_nxt = sub_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sub_d       = sub_q;
        cm_d        = cm_q;
        distance_d  = distance_q;
        valid_d     = valid_q;
        timeout_d   = timeout_q;
        pulse_d     = 1'b0;
        sample_id_d = sample_id_q;
        finish_ok   = 1'b0;
        finish_to   = 1'b0;
        echo_meta_d = echo;
        echo_sync_d = echo_meta_q;
        echo_prev_d = echo_sync_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (tick && us_q == US_W'(TRIG_US - 1)) begin
                    state_d = S_WAIT_ECHO;
                end
            end
            S_WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (tick && us_q == US_W'(ECHO_TIMEOUT_US - 1)) begin
                    finish_to = 1'b1;
                end
            end
            S_MEASURE: begin
                sub_d = sub_nxt;
                cm_d  = cm_nxt;
                if (echo_fall) begin
                    finish_ok = 1'b1;
                end else if (tick && us_q == US_W'(ECHO_TIMEOUT_US - 1)) begin
                    finish_to = 1'b1;
                end
            end
            S_GAP: begin
                if (tick && us_q == US_W'(GAP_US - 1)) begin
                    idx_d   = (idx_q == 2'(NUM_SENSORS - 1)) ? 2'd0 : idx_q + 2'd1;
                    state_d = enable ? S_TRIG : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only the active sensor's slot is written; the others hold.
        if (finish_ok || finish_to) begin
            state_d     = S_GAP;
            pulse_d     = 1'b1;
            sample_id_d = idx_q;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (idx_onehot[i]) begin
                    distance_d[i*10 +: 10] = finish_ok ? cm_nxt : CM_MAX;
                    valid_d[i]             = finish_ok;
                    timeout_d[i]           = finish_to;
                end
            end
        end

        // Timebase restarts on every state entry so each state lasts whole microseconds.
        if (state_d != state_q || state_q == S_IDLE) begin
            presc_d = '0;
            us_d    = '0;
        end else if (tick) begin
            presc_d = '0;
            us_d    = us_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
            us_d    = us_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            presc_q     <= '0;
            us_q        <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            echo_prev_q <= '0;
            distance_q  <= '0;
            valid_q     <= '0;
            timeout_q   <= '0;
            pulse_q     <= 1'b0;
            sample_id_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            us_q        <= us_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            echo_meta_q <= echo_meta_d;
            echo_sync_q <= echo_sync_d;
            echo_prev_q <= echo_prev_d;
            distance_q  <= distance_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            pulse_q     <= pulse_d;
            sample_id_q <= sample_id_d;
        end
    end

    assign trig         = (state_q == S_TRIG) ? idx_onehot : '0;
    assign busy         = (state_q != S_IDLE);
    assign distance     = distance_q;
    assign dist_valid   = valid_q;
    assign timeout      = timeout_q;
    assign sample_pulse = pulse_q;
    assign sample_id    = sample_id_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb/tb_ultrasonic_scan_scheduler.sv - directed bench for ultrasonic_scan_scheduler
// Timing parameters are scaled down so the whole scan sequence stays short.
module tb_ultrasonic_scan_scheduler;

    localparam int NS    = 2;
    localparam int CPU   = 2;
    localparam int TRIGU = 10;
    localparam int TOU   = 1500;
    localparam int GAPU  = 200;
    localparam int UPC   = 58;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [NS-1:0]    echo;
    logic [NS-1:0]    trig;
    logic [NS*10-1:0] distance;
    logic [NS-1:0]    dist_valid;
    logic [NS-1:0]    timeout;
    logic             sample_pulse;
    logic [1:0]       sample_id;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS     (NS),
        .CLK_PER_US      (CPU),
        .TRIG_US         (TRIGU),
        .ECHO_TIMEOUT_US (TOU),
        .GAP_US          (GAPU),
        .US_PER_CM       (UPC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .distance     (distance),
        .dist_valid   (dist_valid),
        .timeout      (timeout),
        .sample_pulse (sample_pulse),
        .sample_id    (sample_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // which: 0/1 = trig[which] high, 2 = trig all low, 3 = sample_pulse, 4 = not busy
    task automatic wait_sig(input int which, input int budget, input string tag, output int stamp);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            case (which)
                0: hit = trig[0];
                1: hit = trig[1];
                2: hit = (trig == '0);
                3: hit = sample_pulse;
                default: hit = !busy;
            endcase
        end
        stamp = cyc;
        if (!hit) chk({tag, "_reached"}, 32'(hit), 1);
    endtask

    task automatic do_echo(input int i, input int width_us, output int ts);
        int t;
        wait_sig(i, 8000, "scan_trig", t);
        wait_sig(2, 100, "scan_trig_fall", t);
        repeat (30) @(negedge clk);
        echo[i] = 1'b1;
        repeat (width_us * CPU) @(negedge clk);
        echo[i] = 1'b0;
        wait_sig(3, 20, "scan_pulse", ts);
    endtask

    initial begin
        int t_rise;
        int t_fall;
        int t_p;
        int t;
        int seen;

        reset  = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) @(negedge clk);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_distance", distance, 0);
        chk("rst_valid", dist_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_pulse", sample_pulse, 0);
        reset  = 1'b0;
        enable = 1'b1;

        // normal measurement on sensor 0: 584 us -> 10 cm
        wait_sig(0, 50, "n_trig0", t_rise);
        chk("n_trig_onehot", trig, 2'b01);
        wait_sig(2, 100, "n_trig_fall", t_fall);
        chk("n_trig_width", t_fall - t_rise, TRIGU * CPU);
        repeat (30) @(negedge clk);
        echo[0] = 1'b1;
        repeat (584 * CPU) @(negedge clk);
        echo[0] = 1'b0;
        wait_sig(3, 20, "n_pulse", t_p);
        chk("n_id", sample_id, 0);
        chk("n_dist0", distance[9:0], 10);
        chk("n_valid0", dist_valid[0], 1);
        chk("n_timeout0", timeout[0], 0);
        @(negedge clk);
        chk("n_pulse_width", sample_pulse, 0);
        wait_sig(1, 1000, "n_trig1", t);
        chk("n_gap", t - t_p, GAPU * CPU);
        chk("n_trig1_onehot", trig, 2'b10);

        // sensor 1 never echoes
        wait_sig(2, 100, "to_trig_fall", t_fall);
        wait_sig(3, TOU * CPU + 100, "to_pulse", t_p);
        chk("to_delay", t_p - t_fall, TOU * CPU);
        chk("to_id", sample_id, 1);
        chk("to_dist1", distance[19:10], 1023);
        chk("to_valid1", dist_valid[1], 0);
        chk("to_timeout1", timeout[1], 1);
        chk("to_dist0_kept", distance[9:0], 10);
        chk("to_valid0_kept", dist_valid[0], 1);

        // rounding boundaries
        do_echo(0, 57, t_p);
        chk("r57_dist", distance[9:0], 0);
        chk("r57_valid", dist_valid[0], 1);
        do_echo(1, 58, t_p);
        chk("r58_dist", distance[19:10], 1);
        chk("r58_valid", dist_valid[1], 1);
        chk("r58_timeout", timeout[1], 0);
        do_echo(0, 1160, t_p);
        chk("r1160_dist", distance[9:0], 20);
        do_echo(1, 100, t_p);
        chk("r100_dist", distance[19:10], 1);

        // echo stuck high on sensor 0 before trigger falls
        wait_sig(0, 1000, "sk_trig0", t);
        echo[0] = 1'b1;
        wait_sig(2, 100, "sk_trig_fall", t_fall);
        wait_sig(3, TOU * CPU + 100, "sk_pulse", t_p);
        chk("sk_delay", t_p - t_fall, TOU * CPU);
        chk("sk_timeout0", timeout[0], 1);
        chk("sk_valid0", dist_valid[0], 0);
        chk("sk_dist0", distance[9:0], 1023);
        chk("sk_dist1_kept", distance[19:10], 1);
        echo[0] = 1'b0;
        do_echo(1, 116, t_p);
        chk("sk_r116", distance[19:10], 2);
        do_echo(0, 290, t_p);
        chk("sk_r290_dist", distance[9:0], 5);
        chk("sk_r290_valid", dist_valid[0], 1);
        chk("sk_r290_timeout", timeout[0], 0);

        // enable dropped mid-measurement on sensor 1
        wait_sig(1, 1000, "ed_trig1", t);
        wait_sig(2, 100, "ed_trig_fall", t);
        repeat (30) @(negedge clk);
        echo[1] = 1'b1;
        repeat (200) @(negedge clk);
        enable = 1'b0;
        repeat (200 * CPU - 200) @(negedge clk);
        echo[1] = 1'b0;
        wait_sig(3, 20, "ed_pulse", t_p);
        chk("ed_id", sample_id, 1);
        chk("ed_dist1", distance[19:10], 3);
        chk("ed_valid1", dist_valid[1], 1);
        wait_sig(4, 1000, "ed_idle", t);
        chk("ed_gap", t - t_p, GAPU * CPU);
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (trig != '0 || busy) seen++;
        end
        chk("ed_quiet", seen, 0);

        // reset during TRIG
        enable = 1'b1;
        wait_sig(0, 50, "rt_trig0", t);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rt_trig", trig, 0);
        chk("rt_busy", busy, 0);
        chk("rt_distance", distance, 0);
        chk("rt_valid", dist_valid, 0);
        chk("rt_timeout", timeout, 0);
        chk("rt_pulse", sample_pulse, 0);
        reset = 1'b0;
        wait_sig(0, 50, "rt_restart", t);
        chk("rt_restart_trig", trig, 2'b01);

        // reset during MEASURE
        wait_sig(2, 100, "rm_trig_fall", t);
        repeat (30) @(negedge clk);
        echo[0] = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_trig", trig, 0);
        chk("rm_busy", busy, 0);
        chk("rm_valid", dist_valid, 0);
        chk("rm_pulse", sample_pulse, 0);
        chk("rm_sample_id", sample_id, 0);
        echo[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_sig(0, 50, "rm_restart", t);
        chk("rm_restart_trig", trig, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ultrasonic_scan_scheduler.md
Name: ultrasonic_scan_scheduler

Overview:
- Time-multiplexes up to 4 HC-SR04-style ultrasonic sensors onto one shared trigger/echo timing engine, at 100 MHz.
- Round-robin sequencing per sensor: fire trigger, time the echo, convert to centimetres, apply timeout, enforce an inter-ping gap.
- Publishes a per-sensor distance register plus valid/timeout flags. Downstream presence and appliance-control logic consumes these outputs.

Parameters:
- NUM_SENSORS, 2, number of sensors scanned (1..4).
- CLK_PER_US, 100, clock cycles per microsecond tick.
- TRIG_US, 10, trigger pulse width in µs.
- ECHO_TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo-high time, in µs.
- GAP_US, 60000, quiet time after each measurement before the next trigger, in µs.
- US_PER_CM, 58, echo µs per centimetre.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanning enable.
- echo  in  NUM_SENSORS  asynchronous echo inputs, bit i = sensor i.
- trig  out  NUM_SENSORS  trigger outputs, one-hot or zero.
- distance  out  NUM_SENSORS*10  packed distances in cm; sensor i occupies bits [10i+9:10i].
- dist_valid  out  NUM_SENSORS  last measurement of sensor i completed normally.
- timeout  out  NUM_SENSORS  last measurement of sensor i timed out.
- sample_pulse  out  1  one-cycle strobe when any sensor result updates.
- sample_id  out  2  sensor index associated with sample_pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset and clock:
  - One clock, clk. reset is synchronous and active-high.
  - Reset values: all outputs 0; state IDLE; sensor index 0; timers 0.
  - Reset asserted mid-operation aborts immediately. trig drops on the first clk edge with reset high.
- Echo input: each echo bit passes through a 2-flop synchronizer. Edges are detected on the synchronized value, so echo edges take effect 2–3 cycles after the pin changes.
- Timebase:
  - A prescaler counts 0..CLK_PER_US-1 and emits a µs tick. A µs counter counts those ticks.
  - Both the prescaler and the µs counter clear on every state entry, so state durations are exact multiples of CLK_PER_US cycles.
- State machine: IDLE, TRIG, WAIT_ECHO, MEASURE, GAP.
  - IDLE: if enable=1, go to TRIG for the current index.
  - TRIG:
    - trig[idx]=1 for exactly TRIG_US*CLK_PER_US cycles (1000 at defaults), then WAIT_ECHO.
    - All other trig bits stay 0 at all times.
  - WAIT_ECHO:
    - A synchronized rising edge on echo[idx] moves to MEASURE and clears the cm counter and the sub-counter.
    - Echo already high on entry is not a rising edge and must go low first.
    - No rise within ECHO_TIMEOUT_US µs is a timeout.
  - MEASURE:
    - Each µs tick increments a sub-counter 0..US_PER_CM-1. Wrap of the sub-counter increments the cm counter.
    - Result is distance = floor(echo_high_µs / US_PER_CM), saturating at 1023.
    - A synchronized falling edge completes the measurement:
      - distance slot ← cm;
      - dist_valid[idx]←1 and timeout[idx]←0;
      - sample_pulse=1 with sample_id=idx;
      - go to GAP.
    - Echo high for ECHO_TIMEOUT_US µs is a timeout.
  - Timeout, from WAIT_ECHO or MEASURE:
    - distance slot ← 1023;
    - dist_valid[idx]←0 and timeout[idx]←1;
    - sample_pulse=1 with sample_id=idx;
    - go to GAP.
  - GAP:
    - Wait GAP_US µs, then idx ← (idx+1) mod NUM_SENSORS.
    - Then go to TRIG if enable=1, else IDLE.
- Enable handling: enable is sampled only in IDLE and at GAP exit. Dropping enable mid-cycle lets the current measurement and its gap complete; no further trigger is issued.
- Output timing: sample_pulse is exactly one cycle wide, and the distance, valid and timeout registers update in the same cycle. Other sensors' slots are never modified.
- busy=1 in TRIG, WAIT_ECHO, MEASURE and GAP.

Test Plan:
- Normal measurement (NUM_SENSORS=2, enable=1 after reset, echo[0] high 584 µs after trig[0] falls):
  - trig[0] high exactly 1000 cycles;
  - sample_pulse with sample_id=0;
  - distance[9:0]=10, dist_valid[0]=1, timeout[0]=0;
  - next trigger is trig[1], exactly 60000 µs after the pulse.
- Rounding boundary: echo widths of 57 µs, 58 µs and 1160 µs yield distance 0, 1 and 20 respectively.
- No echo on sensor 1: sample_pulse fires 30000 µs after trig[1] falls, with distance[19:10]=1023, dist_valid[1]=0, timeout[1]=1; sensor 0 slot unchanged.
- Echo stuck high before trig[0] falls: no MEASURE entry; timeout[0]=1 after 30000 µs. Then release echo and give a 290 µs echo on the next scan: distance=5, dist_valid[0]=1, timeout[0]=0.
- enable dropped during MEASURE: measurement completes normally, GAP runs, then IDLE with busy=0 and no further trig edges for ≥200 ms.
- reset pulsed during TRIG and during MEASURE: on the next edge trig=0, all outputs 0, state IDLE. Scan restarts at sensor 0 once reset clears with enable=1.
